decode_stage: RTL

- Pipelined, parametrised instruction decode stage for the 16-bit naiveCPU ISA.
- Sits between fetch and register-read/execute.
- Accepts one instruction per cycle over a valid/ready handshake and produces a registered decoded bundle: operator, source and destination register indices, extended immediate, write-enable and illegal flag.
- Contains a one-entry skid buffer so in_ready is purely registered, plus a synchronous flush for branch redirect.

---
 rtl/decode_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Decode stage for the 16-bit naiveCPU ISA: valid/ready in, registered decoded bundle out.
// A one-entry skid buffer keeps in_ready a pure register; flush kills everything held.
module decode_stage #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned IMM_W = 16,
  parameter int unsigned OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  operator,
  output logic [REG_W-1:0] reg_a,
  output logic [REG_W-1:0] reg_b,
  output logic [REG_W-1:0] reg_d,
  output logic             wr_en,
  output logic [IMM_W-1:0] imm,
  output logic             illegal
);

  localparam int unsigned BW = OP_W + 3 * REG_W + IMM_W + 2;

  logic [4:0]       op;
  logic [REG_W-1:0] rx, ry, rz;
  logic [OP_W-1:0]  dec_op;
  logic [REG_W-1:0] dec_a, dec_b, dec_d;
  logic [IMM_W-1:0] dec_imm;
  logic             dec_wr, dec_ill;
  logic [BW-1:0]    dec_bus;

  assign op = instr[15:11];
  assign rx = REG_W'(instr[10:8]);
  assign ry = REG_W'(instr[7:5]);
  assign rz = REG_W'(instr[4:2]);

  always_comb begin
    dec_op  = '0;
    dec_a   = '0;
    dec_b   = '0;
    dec_d   = '0;
    dec_imm = '0;
    dec_wr  = 1'b0;
    dec_ill = 1'b0;
    case (op)
      5'b00001: dec_op = OP_W'(4'd0);
      5'b11100: begin
        // Only funct 01 (ADDU) and 11 (SUBU) are defined.
        if (instr[0]) begin
          dec_op = instr[1] ? OP_W'(4'd2) : OP_W'(4'd1);
          dec_a  = rx;
          dec_b  = ry;
          dec_d  = rz;
          dec_wr = 1'b1;
        end else begin
          dec_op  = OP_W'(4'd15);
          dec_ill = 1'b1;
        end
      end
      5'b01001: begin
        dec_op  = OP_W'(4'd3);
        dec_a   = rx;
        dec_d   = rx;
        dec_imm = IMM_W'($signed(instr[7:0]));
        dec_wr  = 1'b1;
      end
      5'b01101: begin
        dec_op  = OP_W'(4'd4);
        dec_d   = rx;
        dec_imm = IMM_W'(instr[7:0]);
        dec_wr  = 1'b1;
      end
      5'b10011: begin
        dec_op  = OP_W'(4'd5);
        dec_a   = rx;
        dec_d   = ry;
        dec_imm = IMM_W'($signed(instr[4:0]));
        dec_wr  = 1'b1;
      end
      5'b11011: begin
        dec_op  = OP_W'(4'd6);
        dec_a   = rx;
        dec_b   = ry;
        dec_imm = IMM_W'($signed(instr[4:0]));
      end
      5'b00010: begin
        dec_op  = OP_W'(4'd7);
        dec_imm = IMM_W'($signed(instr[10:0]));
      end
      5'b00100: begin
        dec_op  = OP_W'(4'd8);
        dec_a   = rx;
        dec_imm = IMM_W'($signed(instr[7:0]));
      end
      default: begin
        dec_op  = OP_W'(4'd15);
        dec_ill = 1'b1;
      end
    endcase
  end

  assign dec_bus = {dec_op, dec_a, dec_b, dec_d, dec_imm, dec_wr, dec_ill};

  logic [BW-1:0] out_q, out_d, skid_q, skid_d;
  logic          out_valid_q, out_valid_d;
  logic          skid_full_q, skid_full_d;
  logic          in_ready_q, in_ready_d;
  logic          accept, out_free;

  assign accept   = in_valid & in_ready_q;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (out_free) begin
      // Skid holds the older instruction, so it drains first.
      if (skid_full_q) begin
        out_d       = skid_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_d       = dec_bus;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d      = dec_bus;
      skid_full_d = 1'b1;
    end
    in_ready_d = ~skid_full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign {operator, reg_a, reg_b, reg_d, imm, wr_en, illegal} = out_q;

endmodule
